// File: rtl/riscv_div_ctrl_if.sv
// Request/response and divider-side bundle of the division sequencer.
// slave = the sequencer itself, master = the issue stage plus divider around it.
interface riscv_div_ctrl_if #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6,
    parameter int TAG_W       = 5
);
    logic                   ReqVld_SI;
    logic                   ReqRdy_SO;
    logic [C_WIDTH-1:0]     ReqOpA_DI;
    logic [C_WIDTH-1:0]     ReqOpB_DI;
    logic [1:0]             ReqOp_SI;
    logic [TAG_W-1:0]       ReqTag_DI;
    logic                   Kill_SI;
    logic                   RspVld_SO;
    logic                   RspRdy_SI;
    logic [C_WIDTH-1:0]     RspRes_DO;
    logic [TAG_W-1:0]       RspTag_DO;
    logic [C_WIDTH-1:0]     DivOpA_DO;
    logic [C_WIDTH-1:0]     DivOpB_DO;
    logic [C_LOG_WIDTH-1:0] DivOpBShift_DO;
    logic                   DivOpBIsZero_SO;
    logic                   DivOpBSign_SO;
    logic [1:0]             DivOpCode_SO;
    logic                   DivInVld_SO;
    logic                   DivOutRdy_SO;
    logic                   DivOutVld_SI;
    logic [C_WIDTH-1:0]     DivRes_DI;

    modport slave (
        input  ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOp_SI, ReqTag_DI, Kill_SI,
               RspRdy_SI, DivOutVld_SI, DivRes_DI,
        output ReqRdy_SO, RspVld_SO, RspRes_DO, RspTag_DO,
               DivOpA_DO, DivOpB_DO, DivOpBShift_DO, DivOpBIsZero_SO,
               DivOpBSign_SO, DivOpCode_SO, DivInVld_SO, DivOutRdy_SO
    );

    modport master (
        output ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOp_SI, ReqTag_DI, Kill_SI,
               RspRdy_SI, DivOutVld_SI, DivRes_DI,
        input  ReqRdy_SO, RspVld_SO, RspRes_DO, RspTag_DO,
               DivOpA_DO, DivOpB_DO, DivOpBShift_DO, DivOpBIsZero_SO,
               DivOpBSign_SO, DivOpCode_SO, DivInVld_SO, DivOutRdy_SO
    );
endinterface

// File: rtl/riscv_div_ctrl.sv
// Sequencer between ALU issue and the serial divider: prepares normalised
// operands, launches one division at a time and buffers its result.
module riscv_div_ctrl #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6,
    parameter int TAG_W       = 5
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    riscv_div_ctrl_if.slave  divIf
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]             state;
    logic                   killed;
    logic [C_WIDTH-1:0]     opAReg;
    logic [C_WIDTH-1:0]     opBReg;
    logic [C_LOG_WIDTH-1:0] shiftReg;
    logic                   zeroReg;
    logic                   signReg;
    logic [1:0]             opReg;
    logic [TAG_W-1:0]       tagReg;
    logic [C_WIDTH-1:0]     resReg;
    logic [C_LOG_WIDTH-1:0] shiftNext;
    logic                   reqRdy;
    logic                   dropResult;

    // Signed ops keep one sign bit at the top, hence the count of redundant sign bits minus one.
    function automatic logic [C_LOG_WIDTH-1:0] calcShift(input logic [C_WIDTH-1:0] b,
                                                         input logic sgn);
        logic                   refBit;
        logic                   stop;
        logic [C_LOG_WIDTH-1:0] cnt;
        refBit = sgn & b[C_WIDTH-1];
        stop   = 1'b0;
        cnt    = '0;
        for (int i = C_WIDTH-1; i >= 0; i--) begin
            if (!stop && (b[i] == refBit)) cnt = cnt + C_LOG_WIDTH'(1);
            else                           stop = 1'b1;
        end
        if (sgn) cnt = cnt - C_LOG_WIDTH'(1);
        return cnt;
    endfunction

    assign shiftNext  = calcShift(divIf.ReqOpB_DI, divIf.ReqOp_SI[0]);
    assign reqRdy     = (state == IDLE) && !divIf.Kill_SI;
    assign dropResult = killed || divIf.Kill_SI;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state    <= IDLE;
            killed   <= 1'b0;
            opAReg   <= '0;
            opBReg   <= '0;
            shiftReg <= '0;
            zeroReg  <= 1'b0;
            signReg  <= 1'b0;
            opReg    <= '0;
            tagReg   <= '0;
            resReg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (divIf.ReqVld_SI && reqRdy) begin
                        opAReg   <= divIf.ReqOpA_DI;
                        opBReg   <= divIf.ReqOpB_DI << shiftNext;
                        shiftReg <= shiftNext;
                        zeroReg  <= (divIf.ReqOpB_DI == '0);
                        signReg  <= divIf.ReqOp_SI[0] & divIf.ReqOpB_DI[C_WIDTH-1];
                        opReg    <= divIf.ReqOp_SI;
                        tagReg   <= divIf.ReqTag_DI;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: state <= divIf.Kill_SI ? IDLE : WAIT;
                // A killed division cannot be aborted, so it is drained and its result dropped.
                WAIT: begin
                    if (divIf.Kill_SI) killed <= 1'b1;
                    if (divIf.DivOutVld_SI) begin
                        if (!dropResult) resReg <= divIf.DivRes_DI;
                        state  <= dropResult ? IDLE : RESP;
                        killed <= 1'b0;
                    end
                end
                RESP: begin
                    if (divIf.Kill_SI || divIf.RspRdy_SI) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign divIf.ReqRdy_SO       = reqRdy;
    assign divIf.RspVld_SO       = (state == RESP);
    assign divIf.RspRes_DO       = resReg;
    assign divIf.RspTag_DO       = tagReg;
    assign divIf.DivOpA_DO       = opAReg;
    assign divIf.DivOpB_DO       = opBReg;
    assign divIf.DivOpBShift_DO  = shiftReg;
    assign divIf.DivOpBIsZero_SO = zeroReg;
    assign divIf.DivOpBSign_SO   = signReg;
    assign divIf.DivOpCode_SO    = opReg;
    assign divIf.DivInVld_SO     = (state == LAUNCH) && !divIf.Kill_SI;
    assign divIf.DivOutRdy_SO    = (state == WAIT);
endmodule
